// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, cause codes, counter sizing.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int SRC_POR = 0;
    // Watchdog cause code is N_REQ + SRC_WDOG_OFS, just past the last requester code.
    localparam int SRC_WDOG_OFS = 1;

    function automatic int cnt_width(input int hold, input int gap, input int wdog);
        int m;
        m = hold;
        if (gap > m) m = gap;
        if (wdog > m) m = wdog;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin arbiter: search starts at ptr and wraps; combinational one-hot grant and index.
module rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    int          j;
    logic [IW-1:0] j_idx;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        vld   = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            j_idx = IW'(j);
            if (!vld && req[j_idx]) begin
                vld        = 1'b1;
                gnt[j_idx] = 1'b1;
                idx        = j_idx;
            end
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all block resets, releases them in stage order, replays on soft-reset grant.
// Optional watchdog restart enabled by defining RST_SEQ_WDOG_EN (adds the wdog_kick port).
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_STAGE  = 4,
    parameter int N_REQ    = 2,
    parameter int HOLD_CYC = 8,
    parameter int GAP_CYC  = 4,
    parameter int WDOG_CYC = 1024,
    parameter int SRC_W    = $clog2(N_REQ + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   sw_rst_req,
`ifdef RST_SEQ_WDOG_EN
    input  logic               wdog_kick,
`endif
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_STAGE-1:0] blk_rst,
    output logic               rst_done,
    output logic               busy,
    output logic [SRC_W-1:0]   src_id
);

    localparam int CW = cnt_width(HOLD_CYC, GAP_CYC, WDOG_CYC);
    localparam int SW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (HOLD_CYC < 1 || GAP_CYC < 1 || N_STAGE < 1 || N_REQ < 1) begin : g_param_check
        $error("rst_seq_ctrl: HOLD_CYC, GAP_CYC, N_STAGE and N_REQ must all be >= 1");
    end

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [SW-1:0]      stage, stage_n;
    logic [PW-1:0]      ptr, ptr_n;
    logic [N_STAGE-1:0] blk_n;
    logic               done_n;
    logic [N_REQ-1:0]   ack_n;
    logic [SRC_W-1:0]   src_n;

    logic [N_REQ-1:0]   gnt;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_vld;

    rr_arb #(.N(N_REQ), .IW(PW)) u_arb (
        .req (sw_rst_req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .vld (gnt_vld)
    );

    always_comb begin
        state_n = state;
        cnt_n   = (cnt == '1) ? cnt : cnt + 1'b1;
        stage_n = stage;
        ptr_n   = ptr;
        blk_n   = blk_rst;
        done_n  = rst_done;
        ack_n   = '0;
        src_n   = src_id;
        case (state)
            ST_ASSERT: begin
                blk_n  = '1;
                done_n = 1'b0;
                if (cnt >= CW'(HOLD_CYC - 1)) begin
                    state_n  = ST_RELEASE;
                    cnt_n    = '0;
                    stage_n  = '0;
                    blk_n[0] = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (cnt >= CW'(GAP_CYC - 1)) begin
                    cnt_n = '0;
                    if (int'(stage) == N_STAGE - 1) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        stage_n        = stage + 1'b1;
                        blk_n[stage_n] = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (gnt_vld) begin
                    state_n = ST_ASSERT;
                    cnt_n   = '0;
                    blk_n   = '1;
                    done_n  = 1'b0;
                    ack_n   = gnt;
                    src_n   = SRC_W'(gnt_idx) + SRC_W'(1);
                    ptr_n   = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
`ifdef RST_SEQ_WDOG_EN
                end else if (wdog_kick) begin
                    cnt_n = '0;
                end else if (cnt >= CW'(WDOG_CYC - 1)) begin
                    state_n = ST_ASSERT;
                    cnt_n   = '0;
                    blk_n   = '1;
                    done_n  = 1'b0;
                    src_n   = SRC_W'(N_REQ + SRC_WDOG_OFS);
                end
`else
                end else begin
                    cnt_n = '0;
                end
`endif
            end
            default: begin
                state_n = ST_ASSERT;
                cnt_n   = '0;
                blk_n   = '1;
                done_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            stage    <= '0;
            ptr      <= '0;
            blk_rst  <= '1;
            rst_done <= 1'b0;
            busy     <= 1'b1;
            req_ack  <= '0;
            src_id   <= SRC_W'(SRC_POR);
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            stage    <= stage_n;
            ptr      <= ptr_n;
            blk_rst  <= blk_n;
            rst_done <= done_n;
            busy     <= !done_n;
            req_ack  <= ack_n;
            src_id   <= src_n;
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: power-on timing, soft-reset grants, mid-sequence reset, watchdog.
module tb_rst_seq_ctrl;

    localparam int N_STAGE = 4;
    localparam int N_REQ   = 2;
    localparam int HOLD    = 8;
    localparam int GAP     = 4;
    localparam int SRC_W   = 2;
    localparam int DONE_C  = HOLD + N_STAGE * GAP;
`ifdef RST_SEQ_WDOG_EN
    localparam int WDOG    = 16;
`else
    localparam int WDOG    = 1024;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_REQ-1:0]   sw_rst_req = '0;
    logic [N_REQ-1:0]   req_ack;
    logic [N_STAGE-1:0] blk_rst;
    logic               rst_done;
    logic               busy;
    logic [SRC_W-1:0]   src_id;
`ifdef RST_SEQ_WDOG_EN
    logic               wdog_kick = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    rst_seq_ctrl #(
        .N_STAGE (N_STAGE),
        .N_REQ   (N_REQ),
        .HOLD_CYC(HOLD),
        .GAP_CYC (GAP),
        .WDOG_CYC(WDOG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_WDOG_EN
        .wdog_kick (wdog_kick),
`endif
        .req_ack   (req_ack),
        .blk_rst   (blk_rst),
        .rst_done  (rst_done),
        .busy      (busy),
        .src_id    (src_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected block resets at cycle c of a sequence (cycle 0 = first cycle after rst / grant).
    function automatic logic [N_STAGE-1:0] exp_blk(input int c);
        logic [N_STAGE-1:0] r;
        for (int k = 0; k < N_STAGE; k++) r[k] = (c < HOLD + k * GAP);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) tick();
        checks++;
        if (blk_rst !== 4'hF || rst_done !== 1'b0 || busy !== 1'b1 || req_ack !== 2'b00 || src_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: blk=%b done=%b busy=%b ack=%b src=%0d, want F/0/1/00/0",
                     blk_rst, rst_done, busy, req_ack, src_id);
        end
        rst = 1'b0;
    endtask

    task automatic test_power_on();
        for (int c = 0; c <= DONE_C; c++) begin
            checks++;
            if (blk_rst !== exp_blk(c)) begin
                errors++;
                $display("FAIL por_blk c=%0d: got %b want %b", c, blk_rst, exp_blk(c));
            end
            checks++;
            if (rst_done !== (c >= DONE_C) || busy !== (c < DONE_C) || src_id !== 2'd0 || req_ack !== 2'b00) begin
                errors++;
                $display("FAIL por_status c=%0d: done=%b busy=%b src=%0d ack=%b", c, rst_done, busy, src_id, req_ack);
            end
            if (c < DONE_C) tick();
        end
    endtask

    task automatic test_single_req();
        sw_rst_req = 2'b10;
        tick();
        checks++;
        if (req_ack !== 2'b10 || src_id !== 2'd2 || blk_rst !== 4'hF || rst_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: ack=%b src=%0d blk=%b done=%b, want 10/2/F/0", req_ack, src_id, blk_rst, rst_done);
        end
        sw_rst_req = 2'b00;
        for (int c = 1; c <= DONE_C; c++) begin
            tick();
            checks++;
            if (blk_rst !== exp_blk(c) || rst_done !== (c >= DONE_C) || req_ack !== 2'b00 || src_id !== 2'd2) begin
                errors++;
                $display("FAIL single_seq c=%0d: blk=%b want %b done=%b ack=%b src=%0d",
                         c, blk_rst, exp_blk(c), rst_done, req_ack, src_id);
            end
        end
    endtask

    task automatic test_simultaneous();
        sw_rst_req = 2'b11;
        tick();
        checks++;
        if (req_ack !== 2'b01 || src_id !== 2'd1) begin
            errors++;
            $display("FAIL rr_first: ack=%b src=%0d, want 01/1", req_ack, src_id);
        end
        for (int c = 1; c <= DONE_C; c++) begin
            tick();
            checks++;
            if (blk_rst !== exp_blk(c) || rst_done !== (c >= DONE_C) || req_ack !== 2'b00) begin
                errors++;
                $display("FAIL rr_seq1 c=%0d: blk=%b want %b done=%b ack=%b", c, blk_rst, exp_blk(c), rst_done, req_ack);
            end
        end
        tick();
        checks++;
        if (req_ack !== 2'b10 || src_id !== 2'd2 || blk_rst !== 4'hF) begin
            errors++;
            $display("FAIL rr_second: ack=%b src=%0d blk=%b, want 10/2/F", req_ack, src_id, blk_rst);
        end
        sw_rst_req = 2'b00;
        for (int c = 1; c <= DONE_C; c++) tick();
        checks++;
        if (rst_done !== 1'b1 || src_id !== 2'd2) begin
            errors++;
            $display("FAIL rr_seq2_end: done=%b src=%0d, want 1/2", rst_done, src_id);
        end
    endtask

    task automatic test_reset_mid();
        sw_rst_req = 2'b01;
        tick();
        sw_rst_req = 2'b00;
        repeat (13) tick();
        checks++;
        if (blk_rst !== 4'b1100) begin
            errors++;
            $display("FAIL mid_pre: blk=%b want 1100", blk_rst);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c <= DONE_C; c++) begin
            checks++;
            if (blk_rst !== exp_blk(c) || rst_done !== (c >= DONE_C) || src_id !== 2'd0 || req_ack !== 2'b00) begin
                errors++;
                $display("FAIL mid_restart c=%0d: blk=%b want %b done=%b src=%0d ack=%b",
                         c, blk_rst, exp_blk(c), rst_done, src_id, req_ack);
            end
            if (c < DONE_C) tick();
        end
        // Pointer was 1 before rst; after rst it must be back at 0.
        sw_rst_req = 2'b11;
        tick();
        sw_rst_req = 2'b00;
        checks++;
        if (req_ack !== 2'b01 || src_id !== 2'd1) begin
            errors++;
            $display("FAIL mid_ptr_reset: ack=%b src=%0d, want 01/1", req_ack, src_id);
        end
        for (int c = 1; c <= DONE_C; c++) tick();
    endtask

    task automatic test_req_during_release();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c <= DONE_C; c++) begin
            if (c == 14) sw_rst_req = 2'b01;
            checks++;
            if (req_ack !== 2'b00 || blk_rst !== exp_blk(c) || rst_done !== (c >= DONE_C)) begin
                errors++;
                $display("FAIL rel_req_wait c=%0d: ack=%b blk=%b want %b done=%b", c, req_ack, blk_rst, exp_blk(c), rst_done);
            end
            if (c < DONE_C) tick();
        end
        tick();
        checks++;
        if (req_ack !== 2'b01 || src_id !== 2'd1 || blk_rst !== 4'hF || rst_done !== 1'b0) begin
            errors++;
            $display("FAIL rel_req_ack: ack=%b src=%0d blk=%b done=%b, want 01/1/F/0", req_ack, src_id, blk_rst, rst_done);
        end
        sw_rst_req = 2'b00;
        tick();
        checks++;
        if (req_ack !== 2'b00) begin
            errors++;
            $display("FAIL rel_ack_pulse: ack=%b want 00", req_ack);
        end
        for (int c = 2; c <= DONE_C; c++) tick();
    endtask

`ifdef RST_SEQ_WDOG_EN
    task automatic test_watchdog();
        for (int d = 0; d < WDOG; d++) begin
            checks++;
            if (rst_done !== 1'b1 || req_ack !== 2'b00) begin
                errors++;
                $display("FAIL wdog_wait d=%0d: done=%b ack=%b", d, rst_done, req_ack);
            end
            tick();
        end
        checks++;
        if (rst_done !== 1'b0 || blk_rst !== 4'hF || src_id !== 2'd3 || req_ack !== 2'b00) begin
            errors++;
            $display("FAIL wdog_fire: done=%b blk=%b src=%0d ack=%b, want 0/F/3/00", rst_done, blk_rst, src_id, req_ack);
        end
        for (int c = 1; c <= DONE_C; c++) begin
            tick();
            checks++;
            if (blk_rst !== exp_blk(c) || rst_done !== (c >= DONE_C)) begin
                errors++;
                $display("FAIL wdog_seq c=%0d: blk=%b want %b done=%b", c, blk_rst, exp_blk(c), rst_done);
            end
        end
        for (int d = 0; d < 46; d++) begin
            checks++;
            if (rst_done !== 1'b1 || src_id !== 2'd3) begin
                errors++;
                $display("FAIL wdog_kicked d=%0d: done=%b src=%0d, want 1/3", d, rst_done, src_id);
            end
            wdog_kick = (d % 10 == 9);
            tick();
        end
        wdog_kick = 1'b0;
    endtask
`else
    task automatic test_no_watchdog();
        for (int d = 0; d < 1100; d++) begin
            checks++;
            if (rst_done !== 1'b1 || src_id !== 2'd1) begin
                errors++;
                $display("FAIL no_wdog d=%0d: done=%b src=%0d, want 1/1", d, rst_done, src_id);
            end
            tick();
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_power_on();
        test_single_req();
        test_simultaneous();
        test_reset_mid();
        test_req_during_release();
`ifdef RST_SEQ_WDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
